// File: rtl/operand_entry_s.sv
// Operand entry front end: synchronizes and debounces the ENTER/CLEAR keys,
// turns debounced presses into one-cycle events and runs a small FSM that
// captures operand A then operand B from the slide switches.
module operand_entry_s #(
  parameter int WIDTH           = 4,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic             iCLK_50,
  input  logic             iRST,
  input  logic [3:0]       iKEY,
  input  logic [WIDTH-1:0] iSW,
  output logic [WIDTH-1:0] oA,
  output logic [WIDTH-1:0] oB,
  output logic             oVALID,
  output logic [1:0]       oSTATE
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter saturates one short of D because the edge that would make it
  // reach D is the same edge that commits the new level and clears it.
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    WAIT_A = 2'd0,
    WAIT_B = 2'd1,
    DONE   = 2'd2,
    BAD    = 2'd3
  } state_t;

  // Only ENTER (KEY0) and CLEAR (KEY1) are used; KEY2/KEY3 are ignored.
  logic [1:0] press_evt;
  logic       unused_keys;
  assign unused_keys = ^iKEY[3:2];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_key
      logic          sync1_q, sync1_d;
      logic          sync2_q, sync2_d;
      logic          deb_q, deb_d;
      logic          deb_prev_q, deb_prev_d;
      logic          evt_q, evt_d;
      logic [CW-1:0] cnt_q, cnt_d;

      // Synchronizer shift, debounce counter and falling-edge event logic.
      always_comb begin
        sync1_d    = iKEY[gi];
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        cnt_d      = '0;
        deb_prev_d = deb_q;
        evt_d      = deb_prev_q & ~deb_q;
        if (sync2_q != deb_q) begin
          if (cnt_q == CNT_LAST) begin
            deb_d = sync2_q;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      // Per-key state registers; keys come out of reset as released.
      always_ff @(posedge iCLK_50) begin
        if (iRST) begin
          sync1_q    <= 1'b1;
          sync2_q    <= 1'b1;
          deb_q      <= 1'b1;
          deb_prev_q <= 1'b1;
          evt_q      <= 1'b0;
          cnt_q      <= '0;
        end else begin
          sync1_q    <= sync1_d;
          sync2_q    <= sync2_d;
          deb_q      <= deb_d;
          deb_prev_q <= deb_prev_d;
          evt_q      <= evt_d;
          cnt_q      <= cnt_d;
        end
      end

      assign press_evt[gi] = evt_q;
    end
  endgenerate

  logic             enter_evt, clear_evt;
  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             valid_q, valid_d;

  assign enter_evt = press_evt[0];
  assign clear_evt = press_evt[1];

  // Entry FSM next state: CLEAR has priority over ENTER in every state.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    valid_d = 1'b0;
    if (clear_evt) begin
      state_d = WAIT_A;
      a_d     = '0;
      b_d     = '0;
    end else begin
      case (state_q)
        WAIT_A: begin
          if (enter_evt) begin
            a_d     = iSW;
            state_d = WAIT_B;
          end
        end
        WAIT_B: begin
          if (enter_evt) begin
            b_d     = iSW;
            valid_d = 1'b1;
            state_d = DONE;
          end
        end
        DONE: begin
          if (enter_evt) begin
            a_d     = iSW;
            state_d = WAIT_B;
          end
        end
        default: begin
          state_d = WAIT_A;
          a_d     = '0;
          b_d     = '0;
        end
      endcase
    end
  end

  // Entry FSM and operand registers.
  always_ff @(posedge iCLK_50) begin
    if (iRST) begin
      state_q <= WAIT_A;
      a_q     <= '0;
      b_q     <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      valid_q <= valid_d;
    end
  end

  assign oA     = a_q;
  assign oB     = b_q;
  assign oVALID = valid_q;
  assign oSTATE = state_q;

endmodule

// File: tb/tb_operand_entry_s.sv
// Bench for operand_entry_s: directed scenarios plus random key activity,
// checked every cycle against a behavioural model of the entry path.
module tb_operand_entry_s;

  localparam int W = 4;
  localparam int D = 4;

  logic         clk = 1'b0;
  logic         iRST;
  logic [3:0]   iKEY;
  logic [W-1:0] iSW;
  logic [W-1:0] oA, oB;
  logic         oVALID;
  logic [1:0]   oSTATE;

  int checks = 0;
  int errors = 0;

  operand_entry_s #(.WIDTH(W), .DEBOUNCE_CYCLES(D)) dut (
    .iCLK_50(clk),
    .iRST   (iRST),
    .iKEY   (iKEY),
    .iSW    (iSW),
    .oA     (oA),
    .oB     (oB),
    .oVALID (oVALID),
    .oSTATE (oSTATE)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // A key press is accepted once the key (seen two samples late through the
  // synchronizer) has disagreed with the accepted level for D straight
  // samples; the FSM reacts two edges after the accepted level drops.
  bit         raw1[2], raw2[2], lvl[2];
  int         run[2];
  bit [1:0]   fell_hist[2];
  bit         act_now[2];
  bit [W-1:0] m_a, m_b;
  bit         m_v;
  int         m_s;
  bit         model_ready = 0;

  always @(posedge clk) begin
    if (iRST) begin
      for (int k = 0; k < 2; k++) begin
        raw1[k] = 1; raw2[k] = 1; lvl[k] = 1; run[k] = 0; fell_hist[k] = 0;
      end
      m_a = 0; m_b = 0; m_v = 0; m_s = 0;
    end else begin
      for (int k = 0; k < 2; k++) begin
        act_now[k]   = fell_hist[k][1];
        fell_hist[k] = {fell_hist[k][0], 1'b0};
        if (raw2[k] != lvl[k]) begin
          run[k]++;
          if (run[k] == D) begin
            lvl[k] = raw2[k];
            run[k] = 0;
            if (!lvl[k]) fell_hist[k][0] = 1'b1;
          end
        end else begin
          run[k] = 0;
        end
        raw2[k] = raw1[k];
        raw1[k] = iKEY[k];
      end
      m_v = 0;
      if (act_now[1]) begin
        m_a = 0; m_b = 0; m_s = 0;
      end else if (act_now[0]) begin
        if (m_s == 0)      begin m_a = iSW; m_s = 1; end
        else if (m_s == 1) begin m_b = iSW; m_v = 1; m_s = 2; end
        else               begin m_a = iSW; m_s = 1; end
      end
    end
    model_ready = 1;
  end

  // ---------------- per-cycle compare ----------------
  bit prev_valid = 0;
  always @(negedge clk) begin
    if (model_ready) begin
      chk("oA",     int'(oA),     int'(m_a));
      chk("oB",     int'(oB),     int'(m_b));
      chk("oVALID", int'(oVALID), int'(m_v));
      chk("oSTATE", int'(oSTATE), m_s);
      if (prev_valid && oVALID) chk("oVALID_back_to_back", 1, 0);
      prev_valid = oVALID;
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  int vcount;
  task automatic tick_count_valid(input int n);
    repeat (n) begin
      @(negedge clk);
      if (oVALID) vcount++;
    end
  endtask

  task automatic press0(input int hold, input int after);
    iKEY[0] = 1'b0;
    tick(hold);
    iKEY[0] = 1'b1;
    tick(after);
  endtask

  initial begin
    iRST = 1'b1;
    iKEY = 4'hF;
    iSW  = '0;
    tick(2);
    // 1. reset state
    chk("rst_oA", int'(oA), 0);
    chk("rst_oB", int'(oB), 0);
    chk("rst_oVALID", int'(oVALID), 0);
    chk("rst_oSTATE", int'(oSTATE), 0);
    iRST = 1'b0;
    tick(2);

    // 2. capture A exactly D+4 = 8 edges after the first low sample
    iSW = 4'h3;
    iKEY[0] = 1'b0;
    tick(7);
    chk("t2_state_edge7", int'(oSTATE), 0);
    tick(1);
    chk("t2_state_edge8", int'(oSTATE), 1);
    chk("t2_oA", int'(oA), 3);
    tick(4);
    iKEY[0] = 1'b1;
    tick(10);
    iSW = 4'hA;
    vcount = 0;
    iKEY[0] = 1'b0;
    tick_count_valid(12);
    iKEY[0] = 1'b1;
    tick_count_valid(10);
    chk("t2_valid_pulses", vcount, 1);
    chk("t2_oB", int'(oB), 10);
    chk("t2_state_done", int'(oSTATE), 2);

    // 3. short press ignored
    iSW = 4'h7;
    press0(3, 12);
    chk("t3_state", int'(oSTATE), 2);
    chk("t3_oA", int'(oA), 3);
    chk("t3_oB", int'(oB), 10);

    // 4. bounce then a steady press: one event, DONE -> WAIT_B with new A
    iSW = 4'h5;
    for (int i = 0; i < 6; i++) begin
      iKEY[0] = ~iKEY[0];
      tick(1);
    end
    iKEY[0] = 1'b0;
    tick(10);
    iKEY[0] = 1'b1;
    tick(10);
    chk("t4_state", int'(oSTATE), 1);
    chk("t4_oA", int'(oA), 5);

    // 5. ENTER and CLEAR together in WAIT_B: CLEAR wins
    iSW = 4'hC;
    vcount = 0;
    iKEY[1:0] = 2'b00;
    tick_count_valid(12);
    iKEY[1:0] = 2'b11;
    tick_count_valid(10);
    chk("t5_state", int'(oSTATE), 0);
    chk("t5_oA", int'(oA), 0);
    chk("t5_oB", int'(oB), 0);
    chk("t5_no_valid", vcount, 0);

    // 6a. reset mid-debounce discards the partial count
    iSW = 4'h7;
    iKEY[0] = 1'b0;
    tick(4);
    iRST = 1'b1;
    iKEY[0] = 1'b1;
    tick(1);
    iRST = 1'b0;
    tick(15);
    chk("t6a_state", int'(oSTATE), 0);
    chk("t6a_oA", int'(oA), 0);

    // 6b. CLEAR held through reset gives one event; ENTER still works after
    iSW = 4'h9;
    press0(8, 10);
    chk("t6b_pre_state", int'(oSTATE), 1);
    iKEY[1] = 1'b0;
    iRST = 1'b1;
    tick(2);
    iRST = 1'b0;
    tick(12);
    chk("t6b_state_clr", int'(oSTATE), 0);
    chk("t6b_oA_clr", int'(oA), 0);
    iSW = 4'h6;
    press0(8, 10);
    chk("t6b_state_enter", int'(oSTATE), 1);
    chk("t6b_oA_enter", int'(oA), 6);
    iKEY[1] = 1'b1;
    tick(10);

    // random phase: bouncy keys, random switches, occasional reset
    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 5) == 0) iKEY[0] = ~iKEY[0];
      if ($urandom_range(0, 7) == 0) iKEY[1] = ~iKEY[1];
      iKEY[3:2] = 2'($urandom_range(0, 3));
      iSW       = W'($urandom_range(0, 15));
      iRST      = ($urandom_range(0, 99) == 0);
      tick(1);
    end
    iRST = 1'b0;
    tick(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
